// File: rtl/fft_spectrum_reader_pkg.sv
// Shared types and helpers for the FFT spectrum reader: FSM states, FIFO sizing, L1 magnitude.
package fft_spectrum_reader_pkg;

  localparam int PKG_FFT_DW = 16;
  localparam int PKG_RD_LAT = 4;
  localparam int FIFO_DEPTH = PKG_RD_LAT + 2;
  localparam int MAG_W      = PKG_FFT_DW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // |re|+|im| in MAG_W bits; the most negative input maps to 2^(DW-1) without saturation.
  function automatic logic [MAG_W-1:0] mag_l1(input logic signed [PKG_FFT_DW-1:0] re,
                                                input logic signed [PKG_FFT_DW-1:0] im);
    logic [MAG_W-1:0] re_x, im_x, re_a, im_a;
    re_x = {re[PKG_FFT_DW-1], re};
    im_x = {im[PKG_FFT_DW-1], im};
    re_a = re[PKG_FFT_DW-1] ? (~re_x + MAG_W'(1)) : re_x;
    im_a = im[PKG_FFT_DW-1] ? (~im_x + MAG_W'(1)) : im_x;
    return re_a + im_a;
  endfunction

endpackage

// File: rtl/fftrd_fifo.sv
// Small synchronous FIFO for the spectrum reader output; overflow is a design error and asserted.
module fftrd_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 6,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_full, w_wr, w_rd;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign w_wr    = i_push && !w_full;
  assign w_rd    = i_pop && !o_empty;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= ptr_inc(r_wp);
      if (w_rd) r_rp <= ptr_inc(r_rp);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      assert (!(i_push && w_full));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end

  assign o_data = r_mem[r_rp];

endmodule

// File: rtl/fft_spectrum_reader.sv
// Reads NBINS FFT bins over the DMA bus after core done and streams |re|+|im| out on valid/ready.
// Optional peak tracker enabled by defining FFTRD_PEAK_EN.
module fft_spectrum_reader
  import fft_spectrum_reader_pkg::*;
#(
  parameter  int FFT_LENGTH = 1024,
  parameter  int FFT_DW     = PKG_FFT_DW,
  parameter  int NBINS      = FFT_LENGTH / 2,
  parameter  int RD_LAT     = PKG_RD_LAT,
  localparam int FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic signed [7:0]        bfpexp_i,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     dmaact_o,
  output logic [FFT_N-1:0]         dmaa_o,
  input  logic signed [FFT_DW-1:0] dmadr_real_i,
  input  logic signed [FFT_DW-1:0] dmadr_imag_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [FFT_N-1:0]         m_bin_o,
  output logic [MAG_W-1:0]         m_mag_o,
  output logic                     m_last_o,
  output logic [7:0]               m_exp_o,
  output logic [FFT_N-1:0]         peak_bin_o,
  output logic [MAG_W-1:0]         peak_mag_o
);

  localparam int FW = FFT_N + MAG_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                       r_state, w_state_nxt;
  logic [FFT_N-1:0]             r_addr;
  logic [7:0]                   r_exp;
  logic                         w_issue, w_start_acc, w_credit;
  logic [RD_LAT-1:0]            r_vld_pipe;
  logic [RD_LAT-1:0][FFT_N-1:0] r_idx_pipe;
  logic                         r_mag_vld, r_mag_last;
  logic [MAG_W-1:0]             r_mag;
  logic [FFT_N-1:0]             r_mag_bin;
  logic [FW-1:0]                w_fifo_dout, w_fifo_q;
  logic                         w_empty, w_pop, w_last_hs;
  logic [CW-1:0]                w_cnt;
  int                           w_occ;

  // Count everything between the DMA issue and the FIFO, net of this cycle's pop, so a
  // slow consumer can never overflow the FIFO regardless of RD_LAT.
  always_comb begin
    w_occ = int'(r_mag_vld) + int'(w_cnt) - int'(w_pop);
    for (int i = 0; i < RD_LAT; i++) w_occ = w_occ + int'(r_vld_pipe[i]);
    w_credit = (w_occ < FIFO_DEPTH);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE: if (start_i) begin
        w_start_acc = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_issue = w_credit;
        if (w_credit && r_addr == FFT_N'(NBINS - 1)) w_state_nxt = DRAIN;
      end
      DRAIN:   if (w_last_hs) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign busy_o       = (r_state == ISSUE) || (r_state == DRAIN);
  assign frame_done_o = (r_state == DONE);
  assign dmaact_o     = w_issue;
  assign dmaa_o       = r_addr;
  assign m_exp_o      = r_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_exp  <= '0;
    end else if (w_start_acc) begin
      r_addr <= '0;
      r_exp  <= bfpexp_i;
    end else if (w_issue && r_addr != FFT_N'(NBINS - 1)) begin
      r_addr <= r_addr + FFT_N'(1);
    end
  end

  // Return path: tag each read with its bin, then register the magnitude once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_idx_pipe <= '0;
      r_mag_vld  <= 1'b0;
      r_mag      <= '0;
      r_mag_bin  <= '0;
      r_mag_last <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LAT-2:0], w_issue};
      r_idx_pipe <= {r_idx_pipe[RD_LAT-2:0], r_addr};
      r_mag_vld  <= r_vld_pipe[RD_LAT-1];
      if (r_vld_pipe[RD_LAT-1]) begin
        r_mag      <= mag_l1(dmadr_real_i, dmadr_imag_i);
        r_mag_bin  <= r_idx_pipe[RD_LAT-1];
        r_mag_last <= (r_idx_pipe[RD_LAT-1] == FFT_N'(NBINS - 1));
      end
    end
  end

  fftrd_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_mag_vld),
    .i_data  ({r_mag_bin, r_mag, r_mag_last}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign w_pop     = !w_empty && m_ready_i;
  assign w_fifo_q  = w_empty ? '0 : w_fifo_dout;
  assign m_valid_o = !w_empty;
  assign m_bin_o   = w_fifo_q[FW-1 -: FFT_N];
  assign m_mag_o   = w_fifo_q[MAG_W:1];
  assign m_last_o  = w_fifo_q[0];
  assign w_last_hs = w_pop && m_last_o;

`ifdef FFTRD_PEAK_EN
  logic             r_run_vld, w_take;
  logic [MAG_W-1:0] r_run_mag, r_peak_mag;
  logic [FFT_N-1:0] r_run_bin, r_peak_bin;

  // Bins arrive in ascending order, so a strict compare keeps the lower bin on ties.
  assign w_take = w_pop && (!r_run_vld || m_mag_o > r_run_mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_vld  <= 1'b0;
      r_run_mag  <= '0;
      r_run_bin  <= '0;
      r_peak_mag <= '0;
      r_peak_bin <= '0;
    end else begin
      if (w_start_acc) begin
        r_run_vld <= 1'b0;
        r_run_mag <= '0;
        r_run_bin <= '0;
      end else if (w_take) begin
        r_run_vld <= 1'b1;
        r_run_mag <= m_mag_o;
        r_run_bin <= m_bin_o;
      end
      if (w_last_hs) begin
        r_peak_mag <= w_take ? m_mag_o : r_run_mag;
        r_peak_bin <= w_take ? m_bin_o : r_run_bin;
      end
    end
  end

  assign peak_bin_o = r_peak_bin;
  assign peak_mag_o = r_peak_mag;
`else
  assign peak_bin_o = '0;
  assign peak_mag_o = '0;
`endif

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// Directed/random bench for fft_spectrum_reader with a behavioural fixed-latency DMA model.
module tb_fft_spectrum_reader;

  localparam int NB = 512;
  localparam int RL = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic signed [7:0]  bfpexp_i = '0;
  logic               busy_o, frame_done_o, dmaact_o;
  logic [9:0]         dmaa_o;
  logic signed [15:0] dmadr_real_i, dmadr_imag_i;
  logic               m_valid_o;
  logic               m_ready_i = 1'b1;
  logic [9:0]         m_bin_o;
  logic [16:0]        m_mag_o;
  logic               m_last_o;
  logic [7:0]         m_exp_o;
  logic [9:0]         peak_bin_o;
  logic [16:0]        peak_mag_o;

  always #5 clk = ~clk;

  fft_spectrum_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .bfpexp_i     (bfpexp_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .dmaact_o     (dmaact_o),
    .dmaa_o       (dmaa_o),
    .dmadr_real_i (dmadr_real_i),
    .dmadr_imag_i (dmadr_imag_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_bin_o      (m_bin_o),
    .m_mag_o      (m_mag_o),
    .m_last_o     (m_last_o),
    .m_exp_o      (m_exp_o),
    .peak_bin_o   (peak_bin_o),
    .peak_mag_o   (peak_mag_o)
  );

  // Bin contents per test mode: 0 -> (k,-k); 1 -> bin 7 is (-32768,-32768); 2 -> bins 100/300 mag 5000, others 10
  int tb_mode = 0;

  function automatic int ref_re(input int mode, input int k);
    case (mode)
      1:       return (k == 7) ? -32768 : k;
      2:       return (k == 100 || k == 300) ? 2500 : 5;
      default: return k;
    endcase
  endfunction

  function automatic int ref_im(input int mode, input int k);
    case (mode)
      1:       return (k == 7) ? -32768 : -k;
      2:       return (k == 100 || k == 300) ? -2500 : -5;
      default: return -k;
    endcase
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // DMA model: data for an address sampled with dmaact_o appears RL cycles later
  logic dl_v [RL] = '{default: 1'b0};
  int   dl_a [RL] = '{default: 0};

  always @(posedge clk) begin
    dl_v[0] <= dmaact_o;
    dl_a[0] <= int'(dmaa_o);
    for (int i = 1; i < RL; i++) begin
      dl_v[i] <= dl_v[i-1];
      dl_a[i] <= dl_a[i-1];
    end
  end

  assign dmadr_real_i = dl_v[RL-1] ? 16'(ref_re(tb_mode, dl_a[RL-1])) : 16'h5A5A;
  assign dmadr_imag_i = dl_v[RL-1] ? 16'(ref_im(tb_mode, dl_a[RL-1])) : 16'hA5A5;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, exp_idx = 0, n_out = 0, n_act = 0, n_done = 0;
  int first_act = -1, first_val = -1, mag7 = -1;
  bit hs_last = 0, rdy_rand = 0;
  logic signed [7:0] exp_exp = '0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic reset_sb();
    exp_idx = 0; n_out = 0; n_act = 0; n_done = 0;
    first_act = -1; first_val = -1; hs_last = 0; mag7 = -1;
  endtask

  task automatic monitor();
    int er, ei;
    cyc++;
    if (dmaact_o) begin
      chk("dmaa", longint'(dmaa_o), longint'(n_act));
      if (first_act < 0) first_act = cyc;
      n_act++;
    end
    if (m_valid_o) begin
      if (first_val < 0) first_val = cyc;
      er = ref_re(tb_mode, exp_idx);
      ei = ref_im(tb_mode, exp_idx);
      chk("bin", longint'(m_bin_o), longint'(exp_idx));
      chk("mag", longint'(m_mag_o), longint'(iabs(er) + iabs(ei)));
      chk("last", longint'(m_last_o), longint'(exp_idx == NB - 1));
      chk("exp", longint'($signed(m_exp_o)), longint'(exp_exp));
      if (m_ready_i) begin
        if (exp_idx == 7) mag7 = int'(m_mag_o);
        hs_last = (exp_idx == NB - 1);
        exp_idx++;
        n_out++;
      end
    end
    if (frame_done_o) begin
      n_done++;
      chk("done_busy", longint'(busy_o), 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rdy_rand) m_ready_i = ($urandom_range(0, 99) < 30);
  endtask

  task automatic run_frame(input logic signed [7:0] e, input bit rnd, input bit extra);
    int k;
    reset_sb();
    rdy_rand  = rnd;
    m_ready_i = 1'b1;
    exp_exp   = e;
    bfpexp_i  = e;
    start_i   = 1'b1;
    step();
    start_i  = 1'b0;
    bfpexp_i = 8'sd5;
    k = 0;
    while (n_done == 0 && k < 8000) begin
      start_i = extra && (k == 40 || k == 300 || k == 500 || hs_last);
      step();
      k++;
    end
    start_i   = 1'b0;
    rdy_rand  = 0;
    m_ready_i = 1'b1;
    chk("frame_timeout", longint'(k < 8000), 1);
    chk("n_out", n_out, NB);
    chk("n_done", n_done, 1);
    chk("n_act", n_act, NB);
    repeat (3) step();
    chk("idle_busy", longint'(busy_o), 0);
    chk("idle_act", n_act, NB);
    chk("once_done", n_done, 1);
    chk("exp_hold", longint'($signed(m_exp_o)), longint'(e));
  endtask

  initial begin
    // 0: reset state
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_act", dmaact_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_exp", m_exp_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // 1: full-rate frame
    tb_mode = 0;
    run_frame(8'sd0, 1'b0, 1'b0);
    chk("latency", first_val - first_act, RL + 2);
`ifdef FFTRD_PEAK_EN
    chk("peak_bin_1", peak_bin_o, 511);
    chk("peak_mag_1", peak_mag_o, 1022);
`else
    chk("peak_bin_off", peak_bin_o, 0);
    chk("peak_mag_off", peak_mag_o, 0);
`endif

    // 2: 30% random ready
    run_frame(8'sd2, 1'b1, 1'b0);

    // 3: most negative re/im on bin 7
    tb_mode = 1;
    run_frame(8'sd1, 1'b0, 1'b0);
    chk("bin7_mag", mag7, 65536);

    // 4: stray start pulses mid-frame and in the done cycle
    tb_mode = 0;
    run_frame(-8'sd3, 1'b0, 1'b1);

    // 5: async reset mid-frame while stalled
    reset_sb();
    exp_exp = 8'sd7; bfpexp_i = 8'sd7; m_ready_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 2000 && n_out < 200; k++) step();
    chk("pre_rst_out", n_out, 200);
    m_ready_i = 1'b0;
    step(); step();
    chk("pre_rst_valid", m_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_done", frame_done_o, 0);
    chk("arst_act", dmaact_o, 0);
    chk("arst_addr", dmaa_o, 0);
    chk("arst_valid", m_valid_o, 0);
    chk("arst_bin", m_bin_o, 0);
    chk("arst_mag", m_mag_o, 0);
    chk("arst_last", m_last_o, 0);
    chk("arst_exp", m_exp_o, 0);
    chk("arst_pbin", peak_bin_o, 0);
    chk("arst_pmag", peak_mag_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready_i = 1'b1;
    step();
    run_frame(8'sd4, 1'b0, 1'b0);

`ifdef FFTRD_PEAK_EN
    // 6: tie between bins 100 and 300 keeps the lower bin
    tb_mode = 2;
    run_frame(8'sd0, 1'b0, 1'b0);
    chk("peak_bin_tie", peak_bin_o, 100);
    chk("peak_mag_tie", peak_mag_o, 5000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
